pulse_round_robin_scheduler: RTL and testbench

- Merges per-channel pulse trains from NUM_CHANNELS requesters onto a single shared pulse output line.
- Each channel has a saturating pending-pulse counter.
- A round-robin scheduler drains the counters one output pulse at a time. Every output pulse is exactly one cycle wide, followed by at least GAP_CYCLES low cycles.
- pulse_source tags each output pulse with its originating channel. Sits in front of shared event sinks such as interrupt lines and counters.

---
 rtl/pulse_round_robin_scheduler.sv | 92 +++++++++
 tb/tb_pulse_round_robin_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_round_robin_scheduler.sv
// pulse_round_robin_scheduler: merges per-channel pulse trains onto one shared line,
// draining saturating pending counters round-robin with a guaranteed low gap between pulses.
module pulse_round_robin_scheduler #(
    parameter int NUM_CHANNELS        = 4,
    parameter int PULSE_COUNTER_WIDTH = 6,
    parameter int GAP_CYCLES          = 1
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [NUM_CHANNELS-1:0]         pulse_in,
    output logic                            pulse_out,
    output logic [$clog2(NUM_CHANNELS)-1:0] pulse_source,
    output logic                            busy,
    output logic [NUM_CHANNELS-1:0]         saturated
);
    localparam int SW = $clog2(NUM_CHANNELS);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int W  = PULSE_COUNTER_WIDTH;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t                         state;
    logic [GW-1:0]                  gap_count;
    logic [SW-1:0]                  ptr;
    logic [SW-1:0]                  winner;
    logic [SW-1:0]                  idx;
    logic [SW-1:0]                  next_ptr;
    logic                           found;
    logic                           grant;
    logic [NUM_CHANNELS-1:0]        nonzero;
    logic [NUM_CHANNELS-1:0]        dec;
    logic [NUM_CHANNELS-1:0][W-1:0] count;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_flags
        assign nonzero[i]   = |count[i];
        assign saturated[i] = &count[i];
    end

    // First nonzero registered count at or after the pointer, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = SW'((int'(ptr) + k) % NUM_CHANNELS);
            if (!found && nonzero[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant    = found && (state == IDLE || (state == GAP && gap_count == '0));
    assign next_ptr = (winner == SW'(NUM_CHANNELS - 1)) ? '0 : winner + 1'b1;
    assign dec      = grant ? (NUM_CHANNELS'(1) << winner) : '0;
    assign busy     = (state != IDLE) || (|nonzero);

    // Increment is dropped at saturation unless the same edge also drains one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                count[c] <= count[c] + W'(pulse_in[c] && !dec[c] && !saturated[c]) - W'(dec[c] && !pulse_in[c]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            gap_count    <= '0;
            ptr          <= '0;
            pulse_out    <= 1'b0;
            pulse_source <= '0;
        end else begin
            pulse_out <= grant;
            if (grant) begin
                state        <= PULSE;
                pulse_source <= winner;
                ptr          <= next_ptr;
            end else if (state == PULSE) begin
                state     <= GAP;
                gap_count <= GW'(GAP_CYCLES - 1);
            end else if (state == GAP) begin
                if (gap_count != '0)
                    gap_count <= gap_count - 1'b1;
                else
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pulse_round_robin_scheduler.sv
// tb_pulse_round_robin_scheduler: directed checks of latency, spacing, round-robin order,
// saturation and asynchronous reset across three parameterisations.
module tb_pulse_round_robin_scheduler;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] pin_a = '0, pin_b = '0, pin_c = '0;
    logic       po_a, po_b, po_c;
    logic [1:0] src_a, src_b, src_c;
    logic       busy_a, busy_b, busy_c;
    logic [3:0] sat_a, sat_b, sat_c;
    int         total = 0;
    int         bad = 0;

    always #5 clock = ~clock;

    pulse_round_robin_scheduler dut_a (
        .clock(clock), .resetn(resetn), .pulse_in(pin_a), .pulse_out(po_a),
        .pulse_source(src_a), .busy(busy_a), .saturated(sat_a)
    );
    pulse_round_robin_scheduler #(.GAP_CYCLES(3)) dut_b (
        .clock(clock), .resetn(resetn), .pulse_in(pin_b), .pulse_out(po_b),
        .pulse_source(src_b), .busy(busy_b), .saturated(sat_b)
    );
    pulse_round_robin_scheduler #(.PULSE_COUNTER_WIDTH(4)) dut_c (
        .clock(clock), .resetn(resetn), .pulse_in(pin_c), .pulse_out(po_c),
        .pulse_source(src_c), .busy(busy_c), .saturated(sat_c)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        pin_a = '0;
        pin_b = '0;
        pin_c = '0;
        step;
        step;
        total++;
        if ({po_a, src_a, busy_a, sat_a} !== 8'h00) begin
            bad++;
            $display("FAIL reset_a outputs=%h want 00", {po_a, src_a, busy_a, sat_a});
        end
        total++;
        if ({po_b, src_b, busy_b, sat_b, po_c, src_c, busy_c, sat_c} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_bc outputs=%h want 0000", {po_b, src_b, busy_b, sat_b, po_c, src_c, busy_c, sat_c});
        end
        resetn = 1'b1;
        step;
    endtask

    task automatic test_single_pulse;
        logic [19:0] exp_p;
        exp_p = 20'h00002;
        pin_a = 4'b0001;
        step;
        pin_a = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step;
            total++;
            if (po_a !== exp_p[k]) begin
                bad++;
                $display("FAIL single k=%0d pulse_out=%b want %b", k, po_a, exp_p[k]);
            end
            if (k == 1) begin
                total++;
                if (src_a !== 2'd0) begin
                    bad++;
                    $display("FAIL single_src pulse_source=%0d want 0", src_a);
                end
            end
            if (k == 2 || k == 3) begin
                total++;
                if (busy_a !== (k == 2)) begin
                    bad++;
                    $display("FAIL single_busy k=%0d busy=%b want %b", k, busy_a, k == 2);
                end
            end
        end
    endtask

    task automatic test_multi_cycle;
        logic [19:0] exp_p;
        exp_p = 20'h000AA;
        pin_a = 4'b0010;
        step;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step;
            if (k == 3) pin_a = 4'b0000;
            total++;
            if (po_a !== exp_p[k]) begin
                bad++;
                $display("FAIL multi k=%0d pulse_out=%b want %b", k, po_a, exp_p[k]);
            end
            if (po_a === 1'b1) begin
                total++;
                if (src_a !== 2'd1) begin
                    bad++;
                    $display("FAIL multi_src k=%0d pulse_source=%0d want 1", k, src_a);
                end
            end
        end
    endtask

    task automatic test_gap3;
        logic [19:0] exp_p;
        exp_p = 20'h00222;
        pin_b = 4'b0100;
        step;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step;
            if (k == 2) pin_b = 4'b0000;
            total++;
            if (po_b !== exp_p[k]) begin
                bad++;
                $display("FAIL gap3 k=%0d pulse_out=%b want %b", k, po_b, exp_p[k]);
            end
            if (po_b === 1'b1) begin
                total++;
                if (src_b !== 2'd2) begin
                    bad++;
                    $display("FAIL gap3_src k=%0d pulse_source=%0d want 2", k, src_b);
                end
            end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] req [2];
        logic [1:0] exp_src [2][3];
        int         n;
        req[0] = 4'b0111;
        req[1] = 4'b1011;
        exp_src[0][0] = 2'd0; exp_src[0][1] = 2'd1; exp_src[0][2] = 2'd2;
        exp_src[1][0] = 2'd3; exp_src[1][1] = 2'd0; exp_src[1][2] = 2'd1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            pin_a = req[r];
            step;
            pin_a = 4'b0000;
            for (int k = 0; k < 12; k++) begin
                if (k > 0) step;
                if (po_a === 1'b1) begin
                    total++;
                    if (n > 2 || src_a !== exp_src[r][n > 2 ? 2 : n]) begin
                        bad++;
                        $display("FAIL rr round=%0d pulse=%0d pulse_source=%0d want %0d", r, n, src_a, exp_src[r][n > 2 ? 2 : n]);
                    end
                    n++;
                end
            end
            total++;
            if (n != 3) begin
                bad++;
                $display("FAIL rr_count round=%0d pulses=%0d want 3", r, n);
            end
        end
    endtask

    task automatic test_saturation;
        int   npulse;
        int   first_sat;
        logic prev;
        npulse = 0;
        first_sat = 0;
        prev = 1'b0;
        pin_c = 4'b0001;
        for (int e = 1; e <= 100; e++) begin
            step;
            if (e == 40) pin_c = 4'b0000;
            if (sat_c[0] === 1'b1 && first_sat == 0) first_sat = e;
            total++;
            if (po_c === 1'b1 && prev === 1'b1) begin
                bad++;
                $display("FAIL sat_width edge=%0d pulse_out high two cycles", e);
            end
            if (po_c === 1'b1) npulse++;
            prev = po_c;
        end
        total++;
        if (first_sat != 29) begin
            bad++;
            $display("FAIL sat_first edge=%0d want 29", first_sat);
        end
        total++;
        if (npulse != 35) begin
            bad++;
            $display("FAIL sat_pulses count=%0d want 35", npulse);
        end
        total++;
        if ({busy_c, sat_c} !== 5'b0) begin
            bad++;
            $display("FAIL sat_drain busy=%b saturated=%b want 0 0000", busy_c, sat_c);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [5:0] exp_p;
        exp_p = 6'b101010;
        pin_a = 4'b0001;
        step;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step;
            total++;
            if (po_a !== exp_p[k]) begin
                bad++;
                $display("FAIL midrst_pre k=%0d pulse_out=%b want %b", k, po_a, exp_p[k]);
            end
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({po_a, busy_a} !== 2'b00) begin
            bad++;
            $display("FAIL midrst_async pulse_out=%b busy=%b want 0 0", po_a, busy_a);
        end
        repeat (4) step;
        pin_a = 4'b0000;
        resetn = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step;
            total++;
            if ({po_a, busy_a} !== 2'b00) begin
                bad++;
                $display("FAIL midrst_after k=%0d pulse_out=%b busy=%b want 0 0", k, po_a, busy_a);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_pulse;
        test_multi_cycle;
        test_gap3;
        test_reset;
        test_round_robin;
        test_saturation;
        test_reset_mid_burst;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
